// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-image loader: word geometry, FSM encoding
// and the byte-lane placement helper.
package mem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // Byte for lane k lands at bits [8k+7:8k] of the word (little-endian).
    function automatic logic [31:0] place_lane(input logic [7:0] b,
                                               input logic [LANE_W-1:0] lane);
        return {24'd0, b} << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Streams a little-endian byte image into 32-bit memory words, then releases
// the core from reset; overflow beyond MAX_WORDS parks the loader in ERR.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        ext_mem_write,
    output logic [31:0] ext_write_data,
    output logic [31:0] ext_data_adr,
    output logic        core_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    state_e              r_state;
    logic [LANE_W-1:0]   r_lane;
    logic [31:0]         r_buf;
    logic [31:0]         r_wdata;
    logic [31:0]         r_adr;
    logic                r_wr;
    logic                r_last_word;
    logic [15:0]         r_wcount;

    logic                w_accept;
    logic                w_word_end;
    logic                w_full;
    logic [31:0]         w_word_buf;
    logic [31:0]         w_next_adr;

    assign w_accept   = in_valid && (r_state == ST_LOAD);
    assign w_word_buf = r_buf | place_lane(in_data, r_lane);
    assign w_word_end = w_accept && ((r_lane == LANE_W'(WORD_BYTES - 1)) || in_last);
    assign w_full     = ({16'd0, r_wcount} == 32'(MAX_WORDS));
    // Address wraps naturally modulo 2^32 in the 32-bit adder.
    assign w_next_adr = BASE_ADDR + {14'd0, r_wcount, 2'b00};

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register in this block sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_lane      <= '0;
            r_buf       <= '0;
            r_wdata     <= '0;
            r_adr       <= BASE_ADDR;
            r_wr        <= 1'b0;
            r_last_word <= 1'b0;
            r_wcount    <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_word_end) begin
                            if (w_full) begin
                                r_state <= ST_ERR;
                            end else begin
                                r_state     <= ST_WRITE;
                                r_wr        <= 1'b1;
                                r_wdata     <= w_word_buf;
                                r_adr       <= w_next_adr;
                                r_last_word <= in_last;
                            end
                        end else begin
                            r_buf  <= w_word_buf;
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    // Clearing here keeps unfilled upper lanes zero on a short final word.
                    r_wcount <= r_wcount + 16'd1;
                    r_lane   <= '0;
                    r_buf    <= '0;
                    r_state  <= r_last_word ? ST_DONE : ST_LOAD;
                end
                default: ;
            endcase
        end
    end

    assign in_ready       = (r_state == ST_LOAD);
    assign ext_mem_write  = r_wr;
    assign ext_write_data = r_wdata;
    assign ext_data_adr   = r_adr;
    assign core_reset     = (r_state != ST_DONE);
    assign done           = (r_state == ST_DONE);
    assign error          = (r_state == ST_ERR);
    assign word_count     = r_wcount;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: three instances (default, MAX_WORDS=2, wrapping base)
// share one byte stream; directed table, hand sequences and random streams.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;

    logic        rdy  [3];
    logic        wr   [3];
    logic [31:0] wd   [3];
    logic [31:0] wa   [3];
    logic        crst [3];
    logic        dn   [3];
    logic        er   [3];
    logic [15:0] wc   [3];

    logic [31:0] base [3] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC};
    int          maxw [3] = '{1024, 2, 1024};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_loader dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy[0]), .ext_mem_write(wr[0]), .ext_write_data(wd[0]), .ext_data_adr(wa[0]),
        .core_reset(crst[0]), .done(dn[0]), .error(er[0]), .word_count(wc[0])
    );

    mem_loader #(.MAX_WORDS(2)) dut_m (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy[1]), .ext_mem_write(wr[1]), .ext_write_data(wd[1]), .ext_data_adr(wa[1]),
        .core_reset(crst[1]), .done(dn[1]), .error(er[1]), .word_count(wc[1])
    );

    mem_loader #(.BASE_ADDR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy[2]), .ext_mem_write(wr[2]), .ext_write_data(wd[2]), .ext_data_adr(wa[2]),
        .core_reset(crst[2]), .done(dn[2]), .error(er[2]), .word_count(wc[2])
    );

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic [31:0] adr;
    } wr_t;

    wr_t mon_q[$];
    wr_t act_q[$];
    wr_t exp_q[$];
    bit  wide    [3];
    bit  prev_wr [3];
    bit  e_done;
    bit  e_err;
    int  e_cnt;

    // Strobe monitor: samples on the falling edge, records every write and
    // flags any strobe that stays high for two consecutive cycles.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (wr[d] === 1'b1) begin
                mon_q.push_back('{d, wd[d], wa[d]});
                if (prev_wr[d]) wide[d] = 1'b1;
            end
            prev_wr[d] = (wr[d] === 1'b1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_last  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        mon_q.delete();
        for (int d = 0; d < 3; d++) wide[d] = 1'b0;
    endtask

    // mode 0: no stalls, 1: valid toggles every cycle, 2: random gaps
    task automatic send(input logic [7:0] b[$], input int mode, input bit mark_last);
        bit ph;
        ph = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            bit acc;
            int guard;
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                bit v;
                case (mode)
                    0:       v = 1'b1;
                    1:       v = ph;
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                ph = !ph;
                if (v) begin
                    in_valid = 1'b1;
                    in_data  = b[i];
                    in_last  = mark_last && (i == b.size() - 1);
                end else begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                end
                @(negedge clk);
                acc = in_valid && rdy[0];
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 40) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: byte %0d not accepted after %0d cycles", i, guard);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Let the final write finish, then offer bytes that must be ignored.
    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reference: split the image into 4-byte words (short tail zero-filled),
    // word i goes to base+4i; reaching MAX_WORDS on a further word is an error.
    task automatic model(input logic [7:0] b[$], input int d);
        int          nw;
        logic [31:0] w;
        exp_q.delete();
        e_done = 1'b0;
        e_err  = 1'b0;
        e_cnt  = 0;
        nw = (b.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            if (i == maxw[d]) begin
                e_err = 1'b1;
                break;
            end
            w = '0;
            for (int k = 0; k < 4; k++)
                if (4 * i + k < b.size()) w[8*k +: 8] = b[4*i + k];
            exp_q.push_back('{d, w, base[d] + 32'(4 * i)});
            e_cnt++;
        end
        e_done = !e_err;
    endtask

    task automatic collect(input int d);
        act_q.delete();
        foreach (mon_q[j]) if (mon_q[j].dut == d) act_q.push_back(mon_q[j]);
    endtask

    task automatic compare_all(input logic [7:0] b[$], input string tag);
        for (int d = 0; d < 3; d++) begin
            model(b, d);
            collect(d);
            check($sformatf("%s d%0d n_writes", tag, d), 32'(act_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
                check($sformatf("%s d%0d w%0d data", tag, d, i), act_q[i].data, exp_q[i].data);
                check($sformatf("%s d%0d w%0d adr", tag, d, i), act_q[i].adr, exp_q[i].adr);
            end
            check($sformatf("%s d%0d strobe_wide", tag, d), 32'(wide[d]), 32'd0);
            check($sformatf("%s d%0d done", tag, d), 32'(dn[d]), 32'(e_done));
            check($sformatf("%s d%0d error", tag, d), 32'(er[d]), 32'(e_err));
            check($sformatf("%s d%0d core_reset", tag, d), 32'(crst[d]), 32'(!e_done));
            check($sformatf("%s d%0d in_ready", tag, d), 32'(rdy[d]), 32'd0);
            check($sformatf("%s d%0d word_count", tag, d), 32'(wc[d]), 32'(e_cnt));
        end
    endtask

    typedef struct {
        logic [95:0] bytes;
        int          n;
        int          mode;
        int          exp_n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          m_err;
    } vec_t;

    vec_t        tbl [5];
    logic [7:0]  b   [$];
    logic [7:0]  full[$];

    initial begin
        tbl[0] = '{bytes: 96'h0010_0593_0000_0513, n: 8, mode: 0, exp_n: 2,
                   w0: 32'h0000_0513, w1: 32'h0010_0593, m_err: 1'b0};
        tbl[1] = '{bytes: 96'h6655_4433_2211, n: 6, mode: 0, exp_n: 2,
                   w0: 32'h4433_2211, w1: 32'h0000_6655, m_err: 1'b0};
        tbl[2] = '{bytes: 96'h0010_0593_0000_0513, n: 8, mode: 1, exp_n: 2,
                   w0: 32'h0000_0513, w1: 32'h0010_0593, m_err: 1'b0};
        tbl[3] = '{bytes: 96'h0C0B_0A09_0807_0605_0403_0201, n: 12, mode: 0, exp_n: 3,
                   w0: 32'h0403_0201, w1: 32'h0807_0605, m_err: 1'b1};
        tbl[4] = '{bytes: 96'hEFBE_ADDE, n: 4, mode: 2, exp_n: 1,
                   w0: 32'hEFBE_ADDE, w1: 32'h0, m_err: 1'b0};

        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        do_reset();

        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst d%0d in_ready", d), 32'(rdy[d]), 32'd1);
            check($sformatf("rst d%0d core_reset", d), 32'(crst[d]), 32'd1);
            check($sformatf("rst d%0d done", d), 32'(dn[d]), 32'd0);
            check($sformatf("rst d%0d error", d), 32'(er[d]), 32'd0);
            check($sformatf("rst d%0d strobe", d), 32'(wr[d]), 32'd0);
            check($sformatf("rst d%0d wdata", d), wd[d], 32'd0);
            check($sformatf("rst d%0d adr", d), wa[d], base[d]);
            check($sformatf("rst d%0d word_count", d), 32'(wc[d]), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            do_reset();
            b.delete();
            for (int k = 0; k < tbl[i].n; k++) b.push_back(tbl[i].bytes[8*k +: 8]);
            send(b, tbl[i].mode, 1'b1);
            settle();
            collect(0);
            check($sformatf("vec%0d a n_writes", i), 32'(act_q.size()), 32'(tbl[i].exp_n));
            if (act_q.size() > 0) begin
                check($sformatf("vec%0d a w0 data", i), act_q[0].data, tbl[i].w0);
                check($sformatf("vec%0d a w0 adr", i), act_q[0].adr, 32'h0);
            end
            if (tbl[i].exp_n > 1 && act_q.size() > 1) begin
                check($sformatf("vec%0d a w1 data", i), act_q[1].data, tbl[i].w1);
                check($sformatf("vec%0d a w1 adr", i), act_q[1].adr, 32'h4);
            end
            check($sformatf("vec%0d m error", i), 32'(er[1]), 32'(tbl[i].m_err));
            collect(2);
            if (act_q.size() > 1)
                check($sformatf("vec%0d b w1 adr wrap", i), act_q[1].adr, 32'h0);
            compare_all(b, $sformatf("vec%0d", i));
        end

        full.delete();
        for (int k = 0; k < 8; k++) full.push_back(tbl[0].bytes[8*k +: 8]);

        // Reset pulsed three bytes into the second word, then a full resend.
        do_reset();
        b.delete();
        for (int k = 0; k < 7; k++) b.push_back(full[k]);
        send(b, 0, 1'b0);
        do_reset();
        check("midword rst word_count", 32'(wc[0]), 32'd0);
        check("midword rst in_ready", 32'(rdy[0]), 32'd1);
        send(full, 0, 1'b1);
        settle();
        collect(0);
        if (act_q.size() > 0) check("midword first adr", act_q[0].adr, 32'h0);
        compare_all(full, "midword");

        // Reset landing on the cycle the first word is being written.
        do_reset();
        b.delete();
        for (int k = 0; k < 4; k++) b.push_back(full[k]);
        send(b, 0, 1'b0);
        do_reset();
        check("midwrite rst strobe", 32'(wr[0]), 32'd0);
        check("midwrite rst adr", wa[0], 32'h0);
        check("midwrite rst word_count", 32'(wc[0]), 32'd0);
        send(full, 0, 1'b1);
        settle();
        compare_all(full, "midwrite");

        for (int r = 0; r < 25; r++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 14);
            b.delete();
            for (int k = 0; k < n; k++) b.push_back(8'($urandom));
            send(b, $urandom_range(0, 2), 1'b1);
            settle();
            compare_all(b, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
